// File: rtl/cpm_fifo_drain.sv
// Read-side drain controller for a show-ahead FIFO: pops a burst of words and
// streams each word out as LSB-first slices on a valid/ready interface.
`timescale 1ns/1ps
module cpm_fifo_drain #(
  parameter int unsigned DATA_WIDTH  = 64,
  parameter int unsigned OUT_WIDTH   = 16,
  parameter int unsigned BURST_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [BURST_WIDTH-1:0] burst_len,
  output logic                   busy,
  output logic                   done,
  output logic [BURST_WIDTH-1:0] word_cnt,
  input  logic                   fifo_empty,
  input  logic [DATA_WIDTH-1:0]  fifo_data,
  output logic                   fifo_pop,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [OUT_WIDTH-1:0]   out_data,
  output logic                   out_last
);

  localparam int unsigned RATIO = DATA_WIDTH / OUT_WIDTH;
  localparam int unsigned SW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [SW-1:0] LAST_SLICE = SW'(RATIO - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_SEND = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]             state_q, state_d;
  logic [BURST_WIDTH-1:0] words_left_q, words_left_d;
  logic [BURST_WIDTH-1:0] word_cnt_q, word_cnt_d;
  logic [DATA_WIDTH-1:0]  shift_q, shift_d;
  logic [SW-1:0]          slice_idx_q, slice_idx_d;
  logic                   slice_last;

  // Next-state, datapath update and the combinational pop strobe
  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    word_cnt_d   = word_cnt_q;
    shift_d      = shift_q;
    slice_idx_d  = slice_idx_q;
    fifo_pop     = 1'b0;
    slice_last   = (slice_idx_q == LAST_SLICE);

    if (Reset) begin
      state_d      = S_IDLE;
      words_left_d = '0;
      word_cnt_d   = '0;
      shift_d      = '0;
      slice_idx_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            word_cnt_d = '0;
            if (burst_len != '0) begin
              words_left_d = burst_len;
              state_d      = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
        end
        S_LOAD: begin
          // Gating on empty makes underflow impossible
          if (!fifo_empty) begin
            fifo_pop    = 1'b1;
            shift_d     = fifo_data;
            slice_idx_d = '0;
            state_d     = S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (!slice_last) begin
              shift_d     = shift_q >> OUT_WIDTH;
              slice_idx_d = slice_idx_q + SW'(1);
            end else begin
              word_cnt_d   = word_cnt_q + BURST_WIDTH'(1);
              words_left_d = words_left_q - BURST_WIDTH'(1);
              state_d      = (words_left_q == BURST_WIDTH'(1)) ? S_DONE : S_LOAD;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      words_left_q <= '0;
      word_cnt_q   <= '0;
      shift_q      <= '0;
      slice_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      word_cnt_q   <= word_cnt_d;
      shift_q      <= shift_d;
      slice_idx_q  <= slice_idx_d;
    end
  end

  // Outputs are direct decodes of registered state, so they hold during stalls
  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign word_cnt  = word_cnt_q;
  assign out_valid = (state_q == S_SEND);
  assign out_data  = shift_q[OUT_WIDTH-1:0];
  assign out_last  = out_valid && (words_left_q == BURST_WIDTH'(1)) && slice_last;

endmodule

// File: tb/tb_cpm_fifo_drain.sv
// Directed bench for cpm_fifo_drain with a small FIFO model and stream monitor.
`timescale 1ns/1ps
module tb_cpm_fifo_drain;

  localparam int unsigned DW = 64;
  localparam int unsigned OW = 16;
  localparam int unsigned BW = 8;

  logic          clk = 1'b0;
  logic          rst_n, Reset, start;
  logic [BW-1:0] burst_len;
  logic          busy, done;
  logic [BW-1:0] word_cnt;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_pop, out_valid, out_ready;
  logic [OW-1:0] out_data;
  logic          out_last;

  cpm_fifo_drain #(.DATA_WIDTH(DW), .OUT_WIDTH(OW), .BURST_WIDTH(BW)) dut (
    .clk(clk), .rst_n(rst_n), .Reset(Reset), .start(start), .burst_len(burst_len),
    .busy(busy), .done(done), .word_cnt(word_cnt), .fifo_empty(fifo_empty),
    .fifo_data(fifo_data), .fifo_pop(fifo_pop), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Show-ahead FIFO model
  logic [DW-1:0] mem [16];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_data  = mem[rd_ptr[3:0]];

  // Monitor: pops, done pulses, accepted slices
  int pop_cnt = 0;
  int done_cnt = 0;
  int bad_pop = 0;
  logic [OW-1:0] got_d [$];
  logic          got_l [$];

  always @(posedge clk) begin
    if (fifo_pop) begin
      rd_ptr  <= rd_ptr + 1;
      pop_cnt <= pop_cnt + 1;
      if (fifo_empty) bad_pop <= bad_pop + 1;
    end
    if (done) done_cnt <= done_cnt + 1;
    if (out_valid && out_ready) begin
      got_d.push_back(out_data);
      got_l.push_back(out_last);
    end
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic push(input logic [DW-1:0] w);
    mem[wr_ptr[3:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic check_word(input string tag, input int idx, input logic [DW-1:0] w,
                            input logic last_word);
    for (int j = 0; j < 4; j++) begin
      chk({tag, "_data"}, 64'(got_d[idx+j]), 64'(w[j*16 +: 16]));
      chk({tag, "_last"}, 64'(got_l[idx+j]), 64'(last_word && (j == 3)));
    end
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick();
      k++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [DW-1:0] W1  = 64'h0004_0003_0002_0001;
  localparam logic [DW-1:0] W2A = 64'h0004_0003_0002_0001;
  localparam logic [DW-1:0] W2B = 64'h0008_0007_0006_0005;
  localparam logic [DW-1:0] W2C = 64'h000C_000B_000A_0009;
  localparam logic [DW-1:0] W3A = 64'h1111_2222_3333_4444;
  localparam logic [DW-1:0] W3B = 64'hAAAA_BBBB_CCCC_DDDD;
  localparam logic [DW-1:0] W5A = 64'h5004_5003_5002_5001;
  localparam logic [DW-1:0] W5B = 64'h6004_6003_6002_6001;
  localparam logic [DW-1:0] W6A = 64'h7004_7003_7002_7001;
  localparam logic [DW-1:0] W6B = 64'h8004_8003_8002_8001;

  initial begin
    int base, p0, d0, b0;
    logic stall, any_pop, waiting;
    logic [OW-1:0] pd;
    logic pl;

    rst_n = 1'b0; Reset = 1'b0; start = 1'b0; burst_len = '0; out_ready = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_wcnt", 64'(word_cnt), 64'd0);
    chk("rst_pop", 64'(fifo_pop), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_last", 64'(out_last), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: single word, cycle-exact
    push(W1);
    out_ready = 1'b1; start = 1'b1; burst_len = 8'd1;
    tick();
    start = 1'b0;
    chk("t1_pop", 64'(fifo_pop), 64'd1);
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_valid0", 64'(out_valid), 64'd0);
    tick();
    chk("t1_s1", 64'(out_data), 64'h1); chk("t1_v1", 64'(out_valid), 64'd1);
    chk("t1_l1", 64'(out_last), 64'd0);
    tick();
    chk("t1_s2", 64'(out_data), 64'h2); chk("t1_l2", 64'(out_last), 64'd0);
    tick();
    chk("t1_s3", 64'(out_data), 64'h3); chk("t1_l3", 64'(out_last), 64'd0);
    tick();
    chk("t1_s4", 64'(out_data), 64'h4); chk("t1_l4", 64'(out_last), 64'd1);
    tick();
    chk("t1_done", 64'(done), 64'd1); chk("t1_wcnt", 64'(word_cnt), 64'd1);
    chk("t1_vdone", 64'(out_valid), 64'd0);
    tick();
    chk("t1_done_off", 64'(done), 64'd0); chk("t1_idle", 64'(busy), 64'd0);

    // 2: three words with out_ready toggling every cycle
    base = got_d.size(); p0 = pop_cnt;
    push(W2A); push(W2B); push(W2C);
    start = 1'b1; burst_len = 8'd3;
    tick();
    start = 1'b0;
    for (int k = 0; k < 80 && !done; k++) begin
      out_ready = ~out_ready;
      stall = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      tick();
      if (stall) begin
        chk("t2_hold_v", 64'(out_valid), 64'd1);
        chk("t2_hold_d", 64'(out_data), 64'(pd));
        chk("t2_hold_l", 64'(out_last), 64'(pl));
      end
    end
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_wcnt", 64'(word_cnt), 64'd3);
    chk("t2_n", 64'(got_d.size() - base), 64'd12);
    if (got_d.size() - base == 12) begin
      check_word("t2_w0", base, W2A, 1'b0);
      check_word("t2_w1", base + 4, W2B, 1'b0);
      check_word("t2_w2", base + 8, W2C, 1'b1);
    end
    chk("t2_pops", 64'(pop_cnt - p0), 64'd3);
    out_ready = 1'b1;
    tick();

    // 3: FIFO starves mid-burst
    base = got_d.size(); p0 = pop_cnt; b0 = bad_pop; d0 = done_cnt;
    start = 1'b1; burst_len = 8'd2;
    tick();
    start = 1'b0;
    any_pop = 1'b0; waiting = 1'b1;
    for (int k = 0; k < 10; k++) begin
      any_pop = any_pop | fifo_pop;
      waiting = waiting & busy & !out_valid;
      tick();
    end
    chk("t3_nopop", 64'(any_pop), 64'd0);
    chk("t3_wait", 64'(waiting), 64'd1);
    push(W3A);
    repeat (5) tick();
    push(W3B);
    wait_done("t3_done", 40);
    chk("t3_wcnt", 64'(word_cnt), 64'd2);
    chk("t3_n", 64'(got_d.size() - base), 64'd8);
    if (got_d.size() - base == 8) begin
      check_word("t3_w0", base, W3A, 1'b0);
      check_word("t3_w1", base + 4, W3B, 1'b1);
    end
    chk("t3_pops", 64'(pop_cnt - p0), 64'd2);
    chk("t3_badpop", 64'(bad_pop - b0), 64'd0);
    tick();
    chk("t3_done_cnt", 64'(done_cnt - d0), 64'd1);
    tick();

    // 4: zero-length burst
    p0 = pop_cnt;
    start = 1'b1; burst_len = 8'd0;
    tick();
    start = 1'b0;
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_busy", 64'(busy), 64'd1);
    chk("t4_wcnt", 64'(word_cnt), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd0);
    tick();
    chk("t4_done_off", 64'(done), 64'd0);
    chk("t4_idle", 64'(busy), 64'd0);
    chk("t4_pops", 64'(pop_cnt - p0), 64'd0);

    // 5: synchronous clear mid-word
    push(W5A); push(W5B);
    out_ready = 1'b0; start = 1'b1; burst_len = 8'd2;
    tick();
    start = 1'b0;
    chk("t5_pop", 64'(fifo_pop), 64'd1);
    tick();
    chk("t5_s1", 64'(out_data), 64'h5001);
    out_ready = 1'b1;
    tick();
    chk("t5_s2", 64'(out_data), 64'h5002);
    out_ready = 1'b0;
    tick();
    chk("t5_hold", 64'(out_data), 64'h5002);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("t5_valid", 64'(out_valid), 64'd0);
    chk("t5_busy", 64'(busy), 64'd0);
    chk("t5_wcnt", 64'(word_cnt), 64'd0);
    chk("t5_data", 64'(out_data), 64'd0);
    base = got_d.size(); p0 = pop_cnt;
    out_ready = 1'b1; start = 1'b1; burst_len = 8'd1;
    tick();
    start = 1'b0;
    wait_done("t5_done", 20);
    chk("t5_n", 64'(got_d.size() - base), 64'd4);
    if (got_d.size() - base == 4) check_word("t5_w", base, W5B, 1'b1);
    chk("t5_pops", 64'(pop_cnt - p0), 64'd1);
    tick();

    // 6: start while busy is ignored
    push(W6A); push(W6B);
    base = got_d.size(); p0 = pop_cnt; d0 = done_cnt;
    start = 1'b1; burst_len = 8'd2;
    tick();
    start = 1'b0;
    repeat (2) tick();
    chk("t6_insend", 64'(out_valid), 64'd1);
    start = 1'b1; burst_len = 8'd5;
    tick();
    start = 1'b0; burst_len = 8'd0;
    wait_done("t6_done", 40);
    chk("t6_wcnt", 64'(word_cnt), 64'd2);
    chk("t6_n", 64'(got_d.size() - base), 64'd8);
    if (got_d.size() - base == 8) begin
      check_word("t6_w0", base, W6A, 1'b0);
      check_word("t6_w1", base + 4, W6B, 1'b1);
    end
    repeat (3) tick();
    chk("t6_idle", 64'(busy), 64'd0);
    chk("t6_pops", 64'(pop_cnt - p0), 64'd2);
    chk("t6_empty", 64'(fifo_empty), 64'd1);
    chk("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
